joystick_conditioner: RTL and testbench

- Sits directly downstream of the ADC joystick decoder and consumes its raw direction levels (x, y, 2 bits each) and button levels (3 bits).
- Synchronizes and debounces all seven inputs, then decodes the directions into signed steps.
- Generates one-cycle button-press pulses.
- Runs a frame-paced fire controller with cooldown and auto-repeat, which feeds the ship/projectile logic.

---
 rtl/joystick_conditioner.sv | 191 +++++++++++++++++++
 tb/tb_joystick_conditioner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_conditioner.sv
// joystick_conditioner
//   Conditions the raw joystick/button levels coming from the ADC joystick
//   decoder: two-flop synchronizers, per-bit debounce, signed direction
//   decode, button-press edge pulses, and a frame-paced fire controller
//   with cooldown and auto-repeat that feeds the ship/projectile logic.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per video frame
//   x_raw[1:0]  in   [0] = right (+), [1] = left (-)
//   y_raw[1:0]  in   [0] = positive, [1] = negative
//   btn_raw[2:0] in  raw button levels, [0] = fire
//   x_db, y_db  out  debounced direction levels
//   btn_db      out  debounced button levels
//   dx, dy      out  signed step (2'b01 = +1, 2'b11 = -1, 2'b00 = 0)
//   btn_press   out  one-cycle pulse per debounced rising edge
//   fire_req    out  one-cycle fire strobe
//   fire_ready  out  high while the fire controller is in READY
module joystick_conditioner #(
  parameter int DB_CYCLES     = 50000,
  parameter int DB_W          = 16,
  parameter int FIRE_COOLDOWN = 12,
  parameter int CD_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [1:0] x_raw,
  input  logic [1:0] y_raw,
  input  logic [2:0] btn_raw,
  output logic [1:0] x_db,
  output logic [1:0] y_db,
  output logic [2:0] btn_db,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic [2:0] btn_press,
  output logic       fire_req,
  output logic       fire_ready
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  // All seven raw bits handled uniformly: {btn[2:0], y[1:0], x[1:0]}
  logic [6:0] raw_all;
  logic [6:0] sync1_reg;
  logic [6:0] sync2_reg;
  logic [6:0] db_all;

  assign raw_all = {btn_raw, y_raw, x_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_all;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debounce: the synchronized level must disagree with the
  // debounced level for DB_CYCLES consecutive cycles before it is adopted.
  // Any cycle of agreement restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_db
      logic [DB_W-1:0] cnt_reg;
      logic            db_bit_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] != db_bit_reg) begin
          if (cnt_reg == DB_LAST) begin
            db_bit_reg <= sync2_reg[gi];
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_ONE;
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign db_all[gi] = db_bit_reg;
    end
  endgenerate

  assign x_db   = db_all[1:0];
  assign y_db   = db_all[3:2];
  assign btn_db = db_all[6:4];

  // Opposing directions pressed together cancel to zero.
  function automatic logic [1:0] dir_step(input logic [1:0] lvl);
    case (lvl)
      2'b01:   return 2'b01;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0] dx_reg;
  logic [1:0] dy_reg;
  logic [2:0] btn_db_d_reg;
  logic [2:0] btn_press_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dx_reg        <= 2'b00;
      dy_reg        <= 2'b00;
      btn_db_d_reg  <= 3'b000;
      btn_press_reg <= 3'b000;
    end else begin
      dx_reg        <= dir_step(x_db);
      dy_reg        <= dir_step(y_db);
      btn_db_d_reg  <= btn_db;
      btn_press_reg <= btn_db & ~btn_db_d_reg;
    end
  end

  assign dx        = dx_reg;
  assign dy        = dy_reg;
  assign btn_press = btn_press_reg;

  // Fire controller. A press seen in READY is latched in pending so a tap
  // that is released before the next frame still fires once. While cooling
  // down, presses are dropped; a held button auto-repeats every
  // FIRE_COOLDOWN frames.
  typedef enum logic {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  state_t          state_reg;
  logic [CD_W-1:0] cd_reg;
  logic            pending_reg;
  logic            fire_req_reg;
  logic            fire_ready_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_READY;
      cd_reg         <= '0;
      pending_reg    <= 1'b0;
      fire_req_reg   <= 1'b0;
      fire_ready_reg <= 1'b1;
    end else begin
      fire_req_reg <= 1'b0;
      case (state_reg)
        ST_READY: begin
          if (frame_tick && (btn_db[0] || pending_reg)) begin
            fire_req_reg   <= 1'b1;
            pending_reg    <= 1'b0;
            cd_reg         <= CD_LOAD;
            state_reg      <= ST_COOLDOWN;
            fire_ready_reg <= 1'b0;
          end else if (btn_press_reg[0]) begin
            pending_reg <= 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick) begin
            if (cd_reg > CD_ONE) begin
              cd_reg <= cd_reg - CD_ONE;
            end else if (btn_db[0]) begin
              fire_req_reg <= 1'b1;
              cd_reg       <= CD_LOAD;
            end else begin
              cd_reg         <= '0;
              state_reg      <= ST_READY;
              fire_ready_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg      <= ST_READY;
          fire_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign fire_req   = fire_req_reg;
  assign fire_ready = fire_ready_reg;

endmodule

// File: tb/tb_joystick_conditioner.sv
// tb_joystick_conditioner
//   Directed stimulus with a scoreboard of expected output snapshots.
//   The stimulus process pushes {cycle, expected output vector} entries;
//   the monitor pops one entry every time the observed output vector
//   changes and compares both the cycle and the value.
module tb_joystick_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] x_raw = 2'b00;
  logic [1:0] y_raw = 2'b00;
  logic [2:0] btn_raw = 3'b000;
  logic [1:0] x_db, y_db, dx, dy;
  logic [2:0] btn_db, btn_press;
  logic       fire_req, fire_ready;

  always #5 clk = ~clk;

  joystick_conditioner #(
    .DB_CYCLES(4), .DB_W(16), .FIRE_COOLDOWN(3), .CD_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .x_raw(x_raw), .y_raw(y_raw), .btn_raw(btn_raw),
    .x_db(x_db), .y_db(y_db), .btn_db(btn_db),
    .dx(dx), .dy(dy), .btn_press(btn_press),
    .fire_req(fire_req), .fire_ready(fire_ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];

  // Expected model of every output field
  logic [1:0] e_xdb = 0, e_ydb = 0, e_dx = 0, e_dy = 0;
  logic [2:0] e_btndb = 0, e_press = 0;
  logic       e_fire = 0, e_ready = 1;

  logic [15:0] obs;
  assign obs = {x_db, y_db, btn_db, dx, dy, btn_press, fire_req, fire_ready};

  task automatic push(input int c);
    exp_t e;
    e.c = c;
    e.v = {e_xdb, e_ydb, e_btndb, e_dx, e_dy, e_press, e_fire, e_ready};
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end else begin
      $display("check %s cyc=%0d value=%h ok", name, cyc, got);
    end
  endtask

  // Monitor: one comparison per observed output change
  logic        mon_en = 1'b0;
  logic [15:0] prev;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (mon_en && (obs !== prev)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, obs, prev);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.c != cyc || mon_e.v !== obs) begin
          failures++;
          $display("FAIL output_event got cyc=%0d val=%h want cyc=%0d val=%h",
                   cyc, obs, mon_e.c, mon_e.v);
        end else begin
          $display("event cyc=%0d out=%h ok", cyc, obs);
        end
      end
      prev = obs;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One-cycle frame tick driven at the negedge where cyc == at,
  // so it is sampled on edge at+1.
  task automatic tick(input int at);
    wait_to(at);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    int k;

    // Reset and quiet period
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    prev    = obs;
    mon_en  = 1'b1;
    wait_to(cyc + 20);
    check("reset_state", obs, 16'h0001);

    // x right: db at +6, dx at +7
    k = cyc;
    e_xdb = 2'b01; push(k + 6);
    e_dx  = 2'b01; push(k + 7);
    x_raw = 2'b01;
    wait_to(k + 12);
    // both x bits: cancels to zero
    k = cyc;
    e_xdb = 2'b11; push(k + 6);
    e_dx  = 2'b00; push(k + 7);
    x_raw = 2'b11;
    wait_to(k + 12);
    k = cyc;
    e_xdb = 2'b00; push(k + 6);
    x_raw = 2'b00;
    wait_to(k + 12);
    // y negative -> -1
    k = cyc;
    e_ydb = 2'b10; push(k + 6);
    e_dy  = 2'b11; push(k + 7);
    y_raw = 2'b10;
    wait_to(k + 12);
    // diagonal from y negative: x right, y positive
    k = cyc;
    e_xdb = 2'b01; e_ydb = 2'b01; push(k + 6);
    e_dx  = 2'b01; e_dy  = 2'b01; push(k + 7);
    x_raw = 2'b01; y_raw = 2'b01;
    wait_to(k + 12);
    k = cyc;
    e_xdb = 2'b00; e_ydb = 2'b00; push(k + 6);
    e_dx  = 2'b00; e_dy  = 2'b00; push(k + 7);
    x_raw = 2'b00; y_raw = 2'b00;
    wait_to(k + 12);

    // 3-cycle glitch on btn[1]: no change at all
    k = cyc;
    btn_raw = 3'b010;
    wait_to(k + 3);
    btn_raw = 3'b000;
    wait_to(k + 15);
    // held 10 cycles: db at +6, press pulse at +7 only
    k = cyc;
    e_btndb = 3'b010; push(k + 6);
    e_press = 3'b010; push(k + 7);
    e_press = 3'b000; push(k + 8);
    e_btndb = 3'b000; push(k + 16);
    btn_raw = 3'b010;
    wait_to(k + 10);
    btn_raw = 3'b000;
    wait_to(k + 22);

    // Fire held, ticks every 10 cycles: fire on 1st, 4th, 7th tick
    k = cyc;
    e_btndb = 3'b001; push(k + 6);
    e_press = 3'b001; push(k + 7);
    e_press = 3'b000; push(k + 8);
    e_fire = 1; e_ready = 0; push(k + 11);
    e_fire = 0; push(k + 12);
    e_fire = 1; push(k + 41);
    e_fire = 0; push(k + 42);
    e_fire = 1; push(k + 71);
    e_fire = 0; push(k + 72);
    e_btndb = 3'b000; push(k + 78);
    e_ready = 1; push(k + 101);
    btn_raw = 3'b001;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) begin
        wait_to(k + 72);
        btn_raw = 3'b000;
      end
      tick(k + 10 * i);
    end
    wait_to(k + 110);

    // Tap released before the tick: pending fires once; tap in COOLDOWN ignored
    k = cyc;
    e_btndb = 3'b001; push(k + 6);
    e_press = 3'b001; push(k + 7);
    e_press = 3'b000; push(k + 8);
    e_btndb = 3'b000; push(k + 11);
    e_fire = 1; e_ready = 0; push(k + 15);
    e_fire = 0; push(k + 16);
    e_btndb = 3'b001; push(k + 26);
    e_press = 3'b001; push(k + 27);
    e_press = 3'b000; push(k + 28);
    e_btndb = 3'b000; push(k + 31);
    e_ready = 1; push(k + 61);
    btn_raw = 3'b001;
    wait_to(k + 5);
    btn_raw = 3'b000;
    tick(k + 14);
    wait_to(k + 20);
    btn_raw = 3'b001;
    wait_to(k + 25);
    btn_raw = 3'b000;
    tick(k + 40);
    tick(k + 50);
    tick(k + 60);
    tick(k + 70);
    wait_to(k + 80);

    // Tick in the same cycle as the press: fires, pending not left set
    k = cyc;
    e_btndb = 3'b001; push(k + 6);
    e_press = 3'b001; push(k + 7);
    e_press = 3'b000; e_fire = 1; e_ready = 0; push(k + 8);
    e_fire = 0; push(k + 9);
    e_btndb = 3'b000; push(k + 11);
    e_ready = 1; push(k + 41);
    btn_raw = 3'b001;
    wait_to(k + 5);
    btn_raw = 3'b000;
    tick(k + 7);
    tick(k + 20);
    tick(k + 30);
    tick(k + 40);
    tick(k + 50);
    wait_to(k + 60);

    // Reset mid-COOLDOWN (cd=2) with fire held
    k = cyc;
    e_btndb = 3'b001; push(k + 6);
    e_press = 3'b001; push(k + 7);
    e_press = 3'b000; push(k + 8);
    e_fire = 1; e_ready = 0; push(k + 11);
    e_fire = 0; push(k + 12);
    e_btndb = 3'b000; e_ready = 1; push(k + 26);
    e_btndb = 3'b001; push(k + 34);
    e_press = 3'b001; push(k + 35);
    e_press = 3'b000; push(k + 36);
    e_fire = 1; e_ready = 0; push(k + 41);
    e_fire = 0; push(k + 42);
    e_btndb = 3'b000; push(k + 51);
    e_ready = 1; push(k + 71);
    btn_raw = 3'b001;
    tick(k + 10);
    tick(k + 20);
    wait_to(k + 25);
    #1 reset_n = 1'b0;
    #1 check("async_reset_ready_req", {14'd0, fire_ready, fire_req}, 16'h0002);
    wait_to(k + 28);
    reset_n = 1'b1;
    tick(k + 30);
    tick(k + 40);
    wait_to(k + 45);
    btn_raw = 3'b000;
    tick(k + 50);
    tick(k + 60);
    tick(k + 70);
    wait_to(k + 85);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover remaining=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
